line_editor: RTL and testbench
==============================

// Module: line_editor
//
// PURPOSE
//   Interactive line-editing stage between rxuart and txuart in the UART
//   line-test design. Collects printable bytes into an internal line buffer
//   and applies backspace/delete. On CR/LF, or when the line reaches
//   LINE_MAX, replays the edited line to the transmitter, followed by a
//   terminator. Replaces raw FIFO buffering with edited, line-at-a-time echo.
//
// PARAMETERS
//   LGLEN     7   log2 of line buffer depth (2^LGLEN bytes)
//   LINE_MAX  80  auto-flush length; legal range 1 .. 2^LGLEN
//
// PORTS
//   i_clk       in   1        system clock
//   i_reset     in   1        asynchronous, active-high reset
//   i_rx_stb    in   1        one-cycle strobe, byte received (rxuart style)
//   i_rx_data   in   8        received byte, valid with i_rx_stb
//   o_tx_stb    out  1        transmit request (txuart style)
//   o_tx_data   out  8        byte to transmit, valid while o_tx_stb
//   i_tx_busy   in   1        transmitter busy; byte accepted on o_tx_stb && !i_tx_busy
//   o_line_len  out  LGLEN+1  bytes currently held in the line buffer
//   o_busy      out  1        high while in FLUSH
//   o_overflow  out  1        sticky: a received byte was dropped
//
// BEHAVIOUR
//   - Reset values: o_tx_stb=0, o_tx_data=8'h00, o_line_len=0, o_busy=0,
//     o_overflow=0, state=COLLECT. Asserting reset mid-FLUSH aborts at once;
//     the partial line is discarded.
//   - COLLECT state, on each i_rx_stb:
//     * 8'h0D or 8'h0A with len>0: go to FLUSH. With len==0: ignored, so a
//       CR/LF pair yields one line and blank lines are not echoed.
//     * 8'h08 or 8'h7F: len <= len-1 if len>0; else ignored.
//     * 8'h20..8'h7E: mem[len] <= byte, len <= len+1. If the new len equals
//       LINE_MAX, go to FLUSH in the same cycle (wrap without a user
//       terminator).
//     * Any other byte: dropped silently; o_overflow is not set.
//   - FLUSH state: replays mem[0..len-1], then the terminator.
//     * Memory read is synchronous. o_tx_stb first rises exactly 2 clocks
//       after the i_rx_stb cycle that caused FLUSH.
//     * After each accepted byte, o_tx_stb is low for exactly one cycle
//       (next fetch), then rises with the next byte.
//     * o_tx_data is held stable while o_tx_stb && i_tx_busy.
//     * Read pointer width is LGLEN+1. Never reads past len-1.
//     * After the final terminator byte is accepted: len <= 0, state <=
//       COLLECT, o_tx_stb low on the next cycle.
//   - Any i_rx_stb during FLUSH: byte dropped, o_overflow <= 1. o_overflow
//     clears only on reset.
//   - o_busy = (state == FLUSH). o_line_len is registered and tracks len.
//   - Buffer writes cannot exceed LINE_MAX because of auto-flush. No
//     wrap-around of the write index.
//
// CONFIGURATION
//   LINE_EDITOR_CRLF_EN
//     defined:   terminator is two bytes, 8'h0D then 8'h0A.
//     undefined: terminator is the single byte 8'h0A.
//   The state machine is otherwise identical; the CR costs one extra
//   accept cycle.
//
// TESTING
//   1. Input "abc",8'h0D with i_tx_busy=0. Expect tx "a","b","c",8'h0A;
//      first o_tx_stb 2 clocks after CR; o_line_len 3->0; o_busy low at end.
//   2. Input "ab",8'h08,"x",8'h0A. Expect tx "a","x",8'h0A. Also: 8'h7F at
//      len=0 leaves len=0 and produces no tx.
//   3. Input 80 bytes of 8'h41, no CR. Expect FLUSH on the 80th strobe,
//      80 x 8'h41 then 8'h0A. A following lone 8'h0D produces no output.
//   4. Input "hi",CR, then "z" during FLUSH. Expect tx "h","i",8'h0A only,
//      o_overflow=1 and held; next line in COLLECT is accepted normally.
//   5. Hold i_tx_busy=1 for 50 cycles mid-line. Expect o_tx_data stable,
//      no byte skipped or duplicated. Reset mid-FLUSH: all outputs 0
//      immediately; "q",CR afterwards yields "q",8'h0A.
//   6. With LINE_EDITOR_CRLF_EN defined, input "ok",8'h0A. Expect tx
//      "o","k",8'h0D,8'h0A.

Source files
------------

// File: rtl/line_editor.sv
// line_editor: edited line-at-a-time echo between rxuart and txuart; define LINE_EDITOR_CRLF_EN for a CR,LF terminator
module line_editor #(
    parameter int LGLEN    = 7,
    parameter int LINE_MAX = 80
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_rx_stb,
    input  logic [7:0]     i_rx_data,
    output logic           o_tx_stb,
    output logic [7:0]     o_tx_data,
    input  logic           i_tx_busy,
    output logic [LGLEN:0] o_line_len,
    output logic           o_busy,
    output logic           o_overflow
);
`ifdef LINE_EDITOR_CRLF_EN
    localparam logic CRLF = 1'b1;
`else
    localparam logic CRLF = 1'b0;
`endif
    localparam logic [LGLEN:0] LMAX = (LGLEN + 1)'(LINE_MAX);
    localparam logic [LGLEN:0] ONE  = (LGLEN + 1)'(1);

    typedef enum logic {COLLECT, FLUSH} state_t;

    state_t         state_q, state_d;
    logic [LGLEN:0] len_q, len_d, rd_q, rd_d;
    logic           stb_q, stb_d, ovf_q, ovf_d, cr_q, cr_d, wr_en;
    logic [7:0]     data_q, data_d;
    logic [7:0]     mem [2**LGLEN];
    logic           is_eol, is_del, is_prn, at_end, last;
    logic [7:0]     term;

    assign is_eol = i_rx_data == 8'h0D || i_rx_data == 8'h0A;
    assign is_del = i_rx_data == 8'h08 || i_rx_data == 8'h7F;
    assign is_prn = i_rx_data >= 8'h20 && i_rx_data <= 8'h7E;
    assign at_end = rd_q == len_q;
    assign term   = (CRLF && !cr_q) ? 8'h0D : 8'h0A;
    assign last   = !CRLF || cr_q;

    // Next state: edit the line in COLLECT; fetch/present/accept handshake per byte in FLUSH
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rd_d    = rd_q;
        stb_d   = stb_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        cr_d    = cr_q;
        wr_en   = 1'b0;
        if (state_q == COLLECT) begin
            rd_d = '0;
            cr_d = 1'b0;
            if (i_rx_stb && is_eol && len_q != '0) begin
                state_d = FLUSH;
            end else if (i_rx_stb && is_del && len_q != '0) begin
                len_d = len_q - ONE;
            end else if (i_rx_stb && is_prn) begin
                wr_en = 1'b1;
                len_d = len_q + ONE;
                state_d = (len_d == LMAX) ? FLUSH : COLLECT;
            end
        end else begin
            ovf_d = ovf_q | i_rx_stb;
            if (!stb_q) begin
                stb_d  = 1'b1;
                data_d = at_end ? term : mem[rd_q[LGLEN-1:0]];
            end else if (!i_tx_busy) begin
                stb_d = 1'b0;
                if (!at_end) begin
                    rd_d = rd_q + ONE;
                end else if (!last) begin
                    cr_d = 1'b1;
                end else begin
                    state_d = COLLECT;
                    len_d   = '0;
                end
            end
        end
    end

    // State and output registers, cleared asynchronously so reset aborts a flush at once
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= COLLECT;
            len_q   <= '0;
            rd_q    <= '0;
            stb_q   <= 1'b0;
            data_q  <= 8'h00;
            ovf_q   <= 1'b0;
            cr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            stb_q   <= stb_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            cr_q    <= cr_d;
        end
    end

    // Line buffer write port; the index never exceeds LINE_MAX-1 thanks to auto-flush
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[len_q[LGLEN-1:0]] <= i_rx_data;
    end

    assign o_tx_stb   = stb_q;
    assign o_tx_data  = data_q;
    assign o_line_len = len_q;
    assign o_busy     = state_q == FLUSH;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_line_editor.sv
// tb_line_editor: scoreboard bench for line_editor against a queue-based line model
module tb_line_editor;
    localparam int LGLEN    = 7;
    localparam int LINE_MAX = 80;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_rx_stb = 1'b0;
    logic [7:0]   i_rx_data = 8'h00;
    logic         i_tx_busy = 1'b0;
    logic         o_tx_stb;
    logic [7:0]   o_tx_data;
    logic [LGLEN:0] o_line_len;
    logic         o_busy;
    logic         o_overflow;

    line_editor #(.LGLEN(LGLEN), .LINE_MAX(LINE_MAX)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data),
        .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
        .o_line_len(o_line_len), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } item_t;

    int         checks = 0;
    int         failures = 0;
    item_t      exp_q[$];
    logic [7:0] line_q[$];
    bit         ovf_m = 1'b0;
    bit         busy_force = 1'b0;
    bit         busy_rnd = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_line();
        foreach (line_q[i]) exp_q.push_back('{line_q[i], 1'b0});
`ifdef LINE_EDITOR_CRLF_EN
        exp_q.push_back('{8'h0D, 1'b0});
`endif
        exp_q.push_back('{8'h0A, 1'b1});
        line_q.delete();
    endtask

    task automatic model(input logic [7:0] b, output bit fl, output int len);
        fl = 1'b0;
        if (b == 8'h0D || b == 8'h0A) begin
            fl = line_q.size() > 0;
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (line_q.size() > 0) line_q.delete(line_q.size() - 1);
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            line_q.push_back(b);
            fl = line_q.size() == LINE_MAX;
        end
        len = line_q.size();
        if (fl) push_line();
    endtask

    task automatic finish_flush();
        int n = 0;
        while (o_busy === 1'b1 && n < 3000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("flush_done", int'(o_busy), 0);
        chk("len_after_flush", int'(o_line_len), 0);
        chk("drained", exp_q.size(), 0);
        chk("overflow", int'(o_overflow), int'(ovf_m));
    endtask

    task automatic send(input logic [7:0] b, input bit wait_done, output bit fl);
        int len;
        model(b, fl, len);
        @(posedge i_clk);
        #1;
        i_rx_stb = 1'b1;
        i_rx_data = b;
        @(posedge i_clk);
        #1;
        i_rx_stb = 1'b0;
        chk("line_len", int'(o_line_len), len);
        chk("busy", int'(o_busy), int'(fl));
        chk("overflow_hold", int'(o_overflow), int'(ovf_m));
        if (fl) begin
            chk("stb_fetch", int'(o_tx_stb), 0);
            @(posedge i_clk);
            #1;
            chk("first_stb", int'(o_tx_stb), 1);
            if (wait_done) finish_flush();
        end
    endtask

    task automatic send_str(input string s, input bit wait_done);
        bit fl;
        for (int i = 0; i < s.len(); i++) send(s[i], wait_done, fl);
    endtask

    task automatic drop(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_rx_stb = 1'b1;
        i_rx_data = b;
        ovf_m = 1'b1;
        @(posedge i_clk);
        #1;
        i_rx_stb = 1'b0;
        chk("overflow_set", int'(o_overflow), 1);
    endtask

    function automatic logic [7:0] rnd_byte(input int tp);
        int r = int'($urandom % 100);
        logic [7:0] v;
        if (r < tp) return ($urandom % 2) ? 8'h0D : 8'h0A;
        if (r < tp + 8) return ($urandom % 2) ? 8'h08 : 8'h7F;
        if (r < tp + 12) begin
            v = 8'($urandom % 32);
            if (v == 8'h08 || v == 8'h0A || v == 8'h0D) v = 8'h01;
            return ($urandom % 2) ? v : (8'h80 | 8'($urandom % 128));
        end
        return 8'h20 + 8'($urandom % 95);
    endfunction

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_busy = busy_force ? 1'b1 : (busy_rnd ? ($urandom % 3 == 0) : 1'b0);
        end
    end

    initial begin
        bit a1, a1l, a2, pstb, pbusy;
        logic [7:0] pdata;
        item_t it;
        a1 = 0; a1l = 0; a2 = 0; pstb = 0; pbusy = 0; pdata = 0;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                a1 = 0; a2 = 0; pstb = 0; pbusy = 0;
            end else begin
                if (pstb && pbusy) begin
                    chk("hold_stb", int'(o_tx_stb), 1);
                    chk("hold_data", int'(o_tx_data), int'(pdata));
                end
                if (a1) chk("gap_after_accept", int'(o_tx_stb), 0);
                if (a2) chk("next_byte_stb", int'(o_tx_stb), 1);
                a2 = a1 && !a1l;
                a1 = 0;
                if (o_tx_stb && !i_tx_busy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_tx actual=%0h required=none", o_tx_data);
                    end else begin
                        it = exp_q.pop_front();
                        checks--;
                        chk("tx_data", int'(o_tx_data), int'(it.d));
                        a1 = 1;
                        a1l = it.last;
                    end
                end
                pstb = o_tx_stb;
                pbusy = i_tx_busy;
                pdata = o_tx_data;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl;
        logic [7:0] b;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_tx_stb", int'(o_tx_stb), 0);
        chk("rst_tx_data", int'(o_tx_data), 0);
        chk("rst_line_len", int'(o_line_len), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_overflow", int'(o_overflow), 0);
        i_reset = 1'b0;

        send_str("abc\r", 1'b1);
        send_str("ab", 1'b1);
        send(8'h08, 1'b1, fl);
        send_str("x\n", 1'b1);
        send(8'h7F, 1'b1, fl);
        send(8'h0D, 1'b1, fl);

        for (int i = 0; i < LINE_MAX; i++) send(8'h41, 1'b1, fl);
        send(8'h0D, 1'b1, fl);

        send_str("hi", 1'b1);
        send(8'h0D, 1'b0, fl);
        drop("z");
        finish_flush();
        send_str("ok\n", 1'b1);

        busy_rnd = 1'b1;
        send_str("abcdef", 1'b1);
        send(8'h0D, 1'b0, fl);
        repeat (3) @(posedge i_clk);
        #1;
        busy_force = 1'b1;
        repeat (50) @(posedge i_clk);
        #1;
        busy_force = 1'b0;
        finish_flush();

        send_str("abcdefgh", 1'b1);
        send(8'h0D, 1'b0, fl);
        busy_force = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        #1;
        chk("amid_tx_stb", int'(o_tx_stb), 0);
        chk("amid_tx_data", int'(o_tx_data), 0);
        chk("amid_line_len", int'(o_line_len), 0);
        chk("amid_busy", int'(o_busy), 0);
        chk("amid_overflow", int'(o_overflow), 0);
        exp_q.delete();
        line_q.delete();
        ovf_m = 1'b0;
        busy_force = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        send_str("q\r", 1'b1);

        for (int i = 0; i < 500; i++) begin
            b = rnd_byte(i < 250 ? 15 : 1);
            send(b, 1'b0, fl);
            if (fl) begin
                if ($urandom % 3 == 0) drop(rnd_byte(15));
                finish_flush();
            end
        end

        repeat (5) @(posedge i_clk);
        chk("final_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
